// File: rtl/mreq_rr_arbiter.sv
// Multi-channel memory-request arbiter: round-robin or fixed-priority selection
// into a one-entry registered output stage with same-cycle refill.
module mreq_rr_arbiter #(
    parameter int NREQ      = 3,
    parameter int IBITS     = 4,
    parameter int AW        = 32,
    parameter int CW        = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_mreqs_valid,
    output logic [NREQ-1:0]      o_mreqs_ready,
    input  logic [NREQ-1:0]      i_mreqs_wr,
    input  logic [NREQ-1:0]      i_mreqs_aincr,
    input  logic [2*NREQ-1:0]    i_mreqs_wsize,
    input  logic [CW*NREQ-1:0]   i_mreqs_wcount,
    input  logic [AW*NREQ-1:0]   i_mreqs_addr,
    output logic                 o_mreq_valid,
    input  logic                 i_mreq_ready,
    output logic                 o_mreq_wr,
    output logic                 o_mreq_aincr,
    output logic [1:0]           o_mreq_wsize,
    output logic [CW-1:0]        o_mreq_wcount,
    output logic [AW-1:0]        o_mreq_addr,
    output logic [IBITS-1:0]     o_mreq_sel
);

    logic             r_valid;
    logic             r_wr;
    logic             r_aincr;
    logic [1:0]       r_wsize;
    logic [CW-1:0]    r_wcount;
    logic [AW-1:0]    r_addr;
    logic [IBITS-1:0] r_sel;
    logic [IBITS-1:0] r_last;

    logic             w_space;
    logic             w_any;
    logic             w_hi_found;
    logic             w_grant;
    logic [IBITS-1:0] w_lo_idx;
    logic [IBITS-1:0] w_hi_idx;
    logic [IBITS-1:0] w_win;
    logic             w_wr;
    logic             w_aincr;
    logic [1:0]       w_wsize;
    logic [CW-1:0]    w_wcount;
    logic [AW-1:0]    w_addr;

    assign w_space = !r_valid || i_mreq_ready;

    // Rotating search split into two scans: lowest valid index above last,
    // else lowest valid overall. This wraps cleanly for any NREQ.
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (i_mreqs_valid[j]) begin
                if (!w_any)
                    w_lo_idx = IBITS'(j);
                if (!w_hi_found && (IBITS'(j) > r_last)) begin
                    w_hi_idx   = IBITS'(j);
                    w_hi_found = 1'b1;
                end
                w_any = 1'b1;
            end
        end

        if (PRIO_MODE != 0)
            w_win = w_lo_idx;
        else
            w_win = w_hi_found ? w_hi_idx : w_lo_idx;

        w_grant = w_any && w_space && !rst;

        o_mreqs_ready = '0;
        w_wr          = 1'b0;
        w_aincr       = 1'b0;
        w_wsize       = '0;
        w_wcount      = '0;
        w_addr        = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IBITS'(j) == w_win) begin
                o_mreqs_ready[j] = w_grant;
                w_wr             = i_mreqs_wr[j];
                w_aincr          = i_mreqs_aincr[j];
                w_wsize          = i_mreqs_wsize[2*j +: 2];
                w_wcount         = i_mreqs_wcount[CW*j +: CW];
                w_addr           = i_mreqs_addr[AW*j +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_wr     <= 1'b0;
            r_aincr  <= 1'b0;
            r_wsize  <= '0;
            r_wcount <= '0;
            r_addr   <= '0;
            r_sel    <= '0;
            r_last   <= IBITS'(NREQ - 1);
        end else if (w_grant) begin
            r_valid  <= 1'b1;
            r_wr     <= w_wr;
            r_aincr  <= w_aincr;
            r_wsize  <= w_wsize;
            r_wcount <= w_wcount;
            r_addr   <= w_addr;
            r_sel    <= w_win;
            r_last   <= w_win;
        end else if (i_mreq_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_mreq_valid  = r_valid;
    assign o_mreq_wr     = r_wr;
    assign o_mreq_aincr  = r_aincr;
    assign o_mreq_wsize  = r_wsize;
    assign o_mreq_wcount = r_wcount;
    assign o_mreq_addr   = r_addr;
    assign o_mreq_sel    = r_sel;

endmodule

// File: tb/tb_mreq_rr_arbiter.sv
// Scoreboard bench for mreq_rr_arbiter: three instances (RR/3, fixed/3, RR/5)
// with directed stimulus; monitors pop expected requests on each consumption.
module tb_mreq_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Channel k fields: sel=k, wr=k[0], aincr=~k[0], wsize=k[1:0],
    // wcount=2<<k, addr=0x800 for ch0 else 0x1000<<(k-1).
    function automatic logic [47:0] exp_pack(input int unsigned k);
        logic [3:0]  s;
        logic [31:0] a;
        s = 4'(k);
        a = (k == 0) ? 32'h0000_0800 : (32'h0000_1000 << (k - 1));
        return {s, s[0], ~s[0], s[1:0], 8'(2 << k), a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shared channel field vectors
    logic [2:0]   wr3, aincr3;
    logic [5:0]   wsize3;
    logic [23:0]  wcount3;
    logic [95:0]  addr3;
    logic [4:0]   wr5, aincr5;
    logic [9:0]   wsize5;
    logic [39:0]  wcount5;
    logic [159:0] addr5;

    // DUT A: NREQ=3 round robin
    logic rst_a = 1'b1, rdy_a = 1'b0;
    logic [2:0] valid_a = '0, ready_a;
    logic o_valid_a, o_wr_a, o_aincr_a;
    logic [1:0] o_wsize_a;
    logic [7:0] o_wcount_a;
    logic [31:0] o_addr_a;
    logic [3:0] o_sel_a;
    logic [47:0] pack_a;
    assign pack_a = {o_sel_a, o_wr_a, o_aincr_a, o_wsize_a, o_wcount_a, o_addr_a};

    mreq_rr_arbiter #(.NREQ(3), .IBITS(4), .AW(32), .CW(8), .PRIO_MODE(0)) u_a (
        .clk(clk), .rst(rst_a),
        .i_mreqs_valid(valid_a), .o_mreqs_ready(ready_a),
        .i_mreqs_wr(wr3), .i_mreqs_aincr(aincr3), .i_mreqs_wsize(wsize3),
        .i_mreqs_wcount(wcount3), .i_mreqs_addr(addr3),
        .o_mreq_valid(o_valid_a), .i_mreq_ready(rdy_a),
        .o_mreq_wr(o_wr_a), .o_mreq_aincr(o_aincr_a), .o_mreq_wsize(o_wsize_a),
        .o_mreq_wcount(o_wcount_a), .o_mreq_addr(o_addr_a), .o_mreq_sel(o_sel_a)
    );

    // DUT B: NREQ=3 fixed priority
    logic rst_b = 1'b1, rdy_b = 1'b0;
    logic [2:0] valid_b = '0, ready_b;
    logic o_valid_b, o_wr_b, o_aincr_b;
    logic [1:0] o_wsize_b;
    logic [7:0] o_wcount_b;
    logic [31:0] o_addr_b;
    logic [3:0] o_sel_b;
    logic [47:0] pack_b;
    assign pack_b = {o_sel_b, o_wr_b, o_aincr_b, o_wsize_b, o_wcount_b, o_addr_b};

    mreq_rr_arbiter #(.NREQ(3), .IBITS(4), .AW(32), .CW(8), .PRIO_MODE(1)) u_b (
        .clk(clk), .rst(rst_b),
        .i_mreqs_valid(valid_b), .o_mreqs_ready(ready_b),
        .i_mreqs_wr(wr3), .i_mreqs_aincr(aincr3), .i_mreqs_wsize(wsize3),
        .i_mreqs_wcount(wcount3), .i_mreqs_addr(addr3),
        .o_mreq_valid(o_valid_b), .i_mreq_ready(rdy_b),
        .o_mreq_wr(o_wr_b), .o_mreq_aincr(o_aincr_b), .o_mreq_wsize(o_wsize_b),
        .o_mreq_wcount(o_wcount_b), .o_mreq_addr(o_addr_b), .o_mreq_sel(o_sel_b)
    );

    // DUT C: NREQ=5, IBITS=3 round robin
    logic rst_c = 1'b1, rdy_c = 1'b0;
    logic [4:0] valid_c = '0, ready_c;
    logic o_valid_c, o_wr_c, o_aincr_c;
    logic [1:0] o_wsize_c;
    logic [7:0] o_wcount_c;
    logic [31:0] o_addr_c;
    logic [2:0] o_sel_c;
    logic [47:0] pack_c;
    assign pack_c = {1'b0, o_sel_c, o_wr_c, o_aincr_c, o_wsize_c, o_wcount_c, o_addr_c};

    mreq_rr_arbiter #(.NREQ(5), .IBITS(3), .AW(32), .CW(8), .PRIO_MODE(0)) u_c (
        .clk(clk), .rst(rst_c),
        .i_mreqs_valid(valid_c), .o_mreqs_ready(ready_c),
        .i_mreqs_wr(wr5), .i_mreqs_aincr(aincr5), .i_mreqs_wsize(wsize5),
        .i_mreqs_wcount(wcount5), .i_mreqs_addr(addr5),
        .o_mreq_valid(o_valid_c), .i_mreq_ready(rdy_c),
        .o_mreq_wr(o_wr_c), .o_mreq_aincr(o_aincr_c), .o_mreq_wsize(o_wsize_c),
        .o_mreq_wcount(o_wcount_c), .o_mreq_addr(o_addr_c), .o_mreq_sel(o_sel_c)
    );

    logic [47:0] q_a[$], q_b[$], q_c[$];

    always @(negedge clk) begin
        if (!rst_a && o_valid_a && rdy_a) begin
            if (q_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mon_a: unexpected output %0h", pack_a);
            end else chk("mon_a", 64'(pack_a), 64'(q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst_b && o_valid_b && rdy_b) begin
            if (q_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mon_b: unexpected output %0h", pack_b);
            end else chk("mon_b", 64'(pack_b), 64'(q_b.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst_c && o_valid_c && rdy_c) begin
            if (q_c.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mon_c: unexpected output %0h", pack_c);
            end else chk("mon_c", 64'(pack_c), 64'(q_c.pop_front()));
        end
    end

    initial begin
        logic [47:0] p;
        for (int unsigned k = 0; k < 5; k++) begin
            p = exp_pack(k);
            wr5[k]              = p[43];
            aincr5[k]           = p[42];
            wsize5[2*k +: 2]    = p[41:40];
            wcount5[8*k +: 8]   = p[39:32];
            addr5[32*k +: 32]   = p[31:0];
            if (k < 3) begin
                wr3[k]            = p[43];
                aincr3[k]         = p[42];
                wsize3[2*k +: 2]  = p[41:40];
                wcount3[8*k +: 8] = p[39:32];
                addr3[32*k +: 32] = p[31:0];
            end
        end

        // ---- DUT A: reset state ----
        rdy_a = 1'b1;
        tick(); tick();
        chk("a_rst_out", 64'({o_valid_a, pack_a}), 64'(0));
        valid_a = 3'b111;
        #1;
        chk("a_rst_ready", 64'(ready_a), 64'(0));

        // ---- all valid, sustained 0,1,2,0,1,2 ----
        q_a.push_back(exp_pack(0)); q_a.push_back(exp_pack(1)); q_a.push_back(exp_pack(2));
        q_a.push_back(exp_pack(0)); q_a.push_back(exp_pack(1)); q_a.push_back(exp_pack(2));
        rst_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("a_rr_cont_valid", 64'(o_valid_a), 64'(1));
        end
        valid_a = 3'b000;
        tick();
        chk("a_drain_clear", 64'(o_valid_a), 64'(0));

        // ---- single channel 1 ----
        valid_a = 3'b010;
        q_a.push_back(exp_pack(1));
        #1;
        chk("a_single_ready", 64'(ready_a), 64'(3'b010));
        tick();
        valid_a = 3'b000;
        chk("a_single_valid", 64'(o_valid_a), 64'(1));
        chk("a_single_sel", 64'(o_sel_a), 64'(1));
        chk("a_single_addr", 64'(o_addr_a), 64'(32'h1000));
        chk("a_single_wcount", 64'(o_wcount_a), 64'(4));
        chk("a_single_wr", 64'(o_wr_a), 64'(1));
        #1;
        chk("a_single_ready_off", 64'(ready_a), 64'(0));
        tick();

        // ---- backpressure hold, last=1 so ch2 then ch0 ----
        rdy_a = 1'b0;
        valid_a = 3'b111;
        q_a.push_back(exp_pack(2)); q_a.push_back(exp_pack(0));
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("a_hold_ready", 64'(ready_a), 64'(0));
            chk("a_hold_fields", 64'({o_valid_a, pack_a}), 64'({1'b1, exp_pack(2)}));
            if (i < 4) tick();
        end
        rdy_a = 1'b1;
        #1;
        chk("a_release_ready", 64'(ready_a), 64'(3'b001));
        tick();
        chk("a_release_sel", 64'({o_valid_a, o_sel_a}), 64'({1'b1, 4'd0}));
        valid_a = 3'b000;
        tick();
        chk("a_release_clear", 64'(o_valid_a), 64'(0));

        // ---- reset mid-transfer ----
        valid_a = 3'b100;
        rdy_a = 1'b0;
        tick();
        chk("a_pre_rst_held", 64'({o_valid_a, o_sel_a}), 64'({1'b1, 4'd2}));
        rst_a = 1'b1;
        rdy_a = 1'b1;
        #1;
        chk("a_rst_mid_ready", 64'(ready_a), 64'(0));
        tick();
        chk("a_rst_mid_out", 64'({o_valid_a, pack_a}), 64'(0));
        valid_a = 3'b110;
        rst_a = 1'b0;
        q_a.push_back(exp_pack(1));
        tick();
        chk("a_post_rst_sel", 64'({o_valid_a, o_sel_a}), 64'({1'b1, 4'd1}));
        valid_a = 3'b000;
        tick(); tick();

        // ---- DUT B: fixed priority, ch0 and ch2 valid ----
        rdy_b = 1'b1;
        tick(); tick();
        valid_b = 3'b101;
        rst_b = 1'b0;
        for (int i = 0; i < 6; i++) q_b.push_back(exp_pack(0));
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("b_prio_ready", 64'(ready_b), 64'(3'b001));
            tick();
        end
        valid_b = 3'b000;
        tick(); tick();

        // ---- DUT C: NREQ=5, ch0 and ch4 alternate ----
        rdy_c = 1'b1;
        tick(); tick();
        valid_c = 5'b10001;
        rst_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q_c.push_back(exp_pack(0));
            q_c.push_back(exp_pack(4));
        end
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("c_rr_ready", 64'(ready_c), (i % 2 == 0) ? 64'(5'b00001) : 64'(5'b10000));
            tick();
            chk("c_sel_range", 64'(o_sel_c <= 3'd4), 64'(1));
        end
        valid_c = 5'b00000;
        tick(); tick();

        chk("a_queue_empty", 64'(q_a.size()), 64'(0));
        chk("b_queue_empty", 64'(q_b.size()), 64'(0));
        chk("c_queue_empty", 64'(q_c.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
